// File: rtl/branch_predict_ctrl_if.sv
// Fetch/EX/flush-network bundle for the branch predictor and resolver.
interface branch_predict_ctrl_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_stall;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_funct3, ex_rs1, ex_rs2,
               ex_pc, ex_target, ex_pred_taken,
        input  if_pred_taken, redirect_valid, redirect_pc, flush,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_funct3, ex_rs1, ex_rs2,
               ex_pc, ex_target, ex_pred_taken,
        output if_pred_taken, redirect_valid, redirect_pc, flush,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit BHT predictor, EX branch resolution, mispredict redirect/flush
// sequencer and branch statistics.

module bht_cell (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       upd,
    input  logic       taken,
    output logic [1:0] ctr
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ctr <= 2'b01;
        else if (upd) begin
            if (taken && ctr != 2'b11)
                ctr <= ctr + 2'd1;
            else if (!taken && ctr != 2'b00)
                ctr <= ctr - 2'd1;
        end
    end
endmodule

module branch_predict_ctrl #(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_predict_ctrl_if.slave  bus
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {RUN, REDIRECT, SQUASH} state_t;

    state_t          state, state_nxt;
    logic [1:0]      ctr [BHT_ENTRIES];
    logic [IDX-1:0]  rd_idx, wr_idx;
    logic            taken, legal, resolve, mispredict;
    logic            redirect_valid_q, flush_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [31:0]     branch_cnt_q, mispredict_cnt_q;
    logic            unused_pc_bits;

    assign rd_idx = bus.if_pc[IDX+1:2];
    assign wr_idx = bus.ex_pc[IDX+1:2];
    assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX+2], bus.if_pc[1:0],
                              bus.ex_pc[XLEN-1:IDX+2], bus.ex_pc[1:0]};

    // Lookup reads the registered counters, so a same-cycle update is not seen.
    assign bus.if_pred_taken = ctr[rd_idx][1];

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        unique case (bus.ex_funct3)
            3'b000: taken = (bus.ex_rs1 == bus.ex_rs2);
            3'b001: taken = (bus.ex_rs1 != bus.ex_rs2);
            3'b100: taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101: taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110: taken = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111: taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    // Anything arriving in EX while not in RUN is wrong-path and is dropped.
    assign resolve    = bus.ex_valid && !bus.ex_stall && (state == RUN) && legal;
    assign mispredict = resolve && (taken != bus.ex_pred_taken);

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        localparam logic [IDX-1:0] GI = IDX'(g);
        bht_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .upd     (resolve && (wr_idx == GI)),
            .taken   (taken),
            .ctr     (ctr[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mispredict) state_nxt = REDIRECT;
            REDIRECT: state_nxt = SQUASH;
            SQUASH:   state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Outputs registered from next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= (state_nxt == REDIRECT);
            flush_q          <= (state_nxt != RUN);
            if (mispredict)
                redirect_pc_q <= taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (resolve && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict && mispredict_cnt_q != '1)
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;
endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and resolution controller for the pipelined RISC-V core. It does four things:
- Holds a table of 2-bit saturating counters that predicts taken/not-taken at fetch.
- Resolves conditional branches in EX from funct3 and the two operands.
- On a misprediction, sequences a PC redirect and a two-cycle pipeline flush.
- Keeps branch and mispredict statistics.

It sits between the fetch PC logic, the ID/EX pipeline register and the hazard/flush network.

## Interface
Parameters:
- XLEN, 64, operand and PC width.
- BHT_ENTRIES, 16, number of prediction counters; power of two, minimum 2. IDX = log2(BHT_ENTRIES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  PC being fetched.
- if_pred_taken  out  1  combinational prediction for if_pc.
- ex_valid  in  1  conditional branch present in EX.
- ex_stall  in  1  EX held this cycle; no resolution.
- ex_funct3  in  3  branch funct3.
- ex_rs1, ex_rs2  in  XLEN  compare operands, after forwarding.
- ex_pc  in  XLEN  PC of the branch in EX.
- ex_target  in  XLEN  computed branch target.
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipeline.
- redirect_valid  out  1  registered; fetch loads redirect_pc.
- redirect_pc  out  XLEN  registered corrected PC.
- flush  out  1  registered; squash IF/ID and ID/EX.
- branch_count  out  32  resolved branches, saturating.
- mispredict_count  out  32  mispredictions, saturating.

## Operation
- **BHT lookup.**
  - Index is if_pc[IDX+1:2].
  - if_pred_taken = counter[1].
  - Counter reset value is 2'b01 (weakly not-taken).
- **Condition by funct3 (resolve):**
  - 000: taken if rs1 == rs2.
  - 001: taken if rs1 != rs2.
  - 100: taken if rs1 < rs2, signed.
  - 101: taken if rs1 >= rs2, signed.
  - 110: taken if rs1 < rs2, unsigned.
  - 111: taken if rs1 >= rs2, unsigned.
  - 010 and 011: not a branch. No counter update, no count, no redirect.
- **Resolve event.** Occurs when ex_valid && !ex_stall && state == RUN && funct3 is legal.
  - Counter at index ex_pc[IDX+1:2] moves +1 if taken, -1 if not; saturates at 00 and 11.
  - branch_count increments.
  - Mispredict when actual != ex_pred_taken. Then mispredict_count increments and the FSM goes to REDIRECT.
  - redirect_pc = ex_target if taken, else ex_pc + 4 (mod 2^XLEN).
- **FSM:**
  - RUN: flush = 0, redirect_valid = 0. On mispredict, go to REDIRECT.
  - REDIRECT: redirect_valid = 1, flush = 1. Next state is SQUASH unconditionally.
  - SQUASH: flush = 1, redirect_valid = 0. Next state is RUN.
- **Wrong-path suppression.** In REDIRECT and SQUASH, ex_valid is ignored: no update, no count, no redirect.
- **Counters** saturate at 32'hFFFF_FFFF. They do not wrap.
- **Same-cycle lookup and update, same index.** The lookup returns the pre-update value.

## Timing
- **Reset.** Asserting reset_n low immediately forces:
  - state = RUN.
  - redirect_valid = 0, flush = 0, redirect_pc = 0.
  - branch_count = 0, mispredict_count = 0.
  - All BHT counters = 01.
  - Reset mid-REDIRECT or mid-SQUASH aborts the sequence with no residual flush.
- if_pred_taken has zero latency (combinational from BHT and if_pc).
- Resolution at edge N:
  - redirect_valid and flush are high in cycle N+1.
  - flush alone is high in cycle N+2.
  - RUN resumes in cycle N+3.
- A BHT update at edge N is visible to lookups from cycle N+1.
- A correctly predicted branch produces no output pulse. Back-to-back correct resolutions are accepted every cycle.
- ex_stall high: state and tables are held. An FSM already in REDIRECT or SQUASH still advances (flush is not stalled).

## Test plan
- **Reset defaults.** Deassert reset, then apply if_pc = 0x100 → if_pred_taken = 0. All outputs and counts are 0.
- **Mispredict, taken.** BEQ with rs1 = rs2 = 5, ex_pc = 0x200, ex_target = 0x240, ex_pred_taken = 0 → in cycle N+1, redirect_valid = 1, redirect_pc = 0x240, flush = 1. Cycle N+2: flush = 1 only. mispredict_count = 1. Lookup of 0x200 now predicts taken (counter 10).
- **Signed vs unsigned.** rs1 = 0xFFFF_FFFF_FFFF_FFFF, rs2 = 1:
  - funct3 100 → taken.
  - funct3 110 → not taken.
  - With ex_pred_taken = 1 on the 110 case → redirect_pc = ex_pc + 4.
- **Wrong-path suppression.** A second mispredicting ex_valid presented during REDIRECT and SQUASH → no extra redirect. branch_count increments only once.
- **Saturation and aliasing.** Resolve taken 4× at pc 0x0 → counter sticks at 11. A branch at pc 0x40 (BHT_ENTRIES = 16) aliases the same entry and predicts taken.
- **Stall, illegal funct3, reset.**
  - ex_stall = 1 with a valid mispredict → no change.
  - funct3 010 → ignored.
  - reset_n low during SQUASH → flush drops immediately and counts clear.
